anc_pipeline_sequencer: RTL and testbench

ANC_PIPELINE_SEQUENCER -- requirements
Module: anc_pipeline_sequencer

---
 rtl/anc_pipeline_sequencer.sv | 76 +++++++
 tb/tb_anc_pipeline_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/anc_pipeline_sequencer.sv
// anc_pipeline_sequencer: steps LP -> CS -> (LMS) -> FIR once per ambient sample,
// with a one-deep pending sample, per-stage timeout abort and sticky overrun/timeout flags.
module anc_pipeline_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        sample_ready_in,
  input  logic        adapt_en_in,
  input  logic        clear_flags_in,
  input  logic        lp_done_in,
  input  logic        cs_done_in,
  input  logic        lms_done_in,
  input  logic        fir_done_in,
  output logic        lp_start_out,
  output logic        cs_start_out,
  output logic        lms_start_out,
  output logic        fir_start_out,
  output logic        busy_out,
  output logic        frame_done_out,
  output logic        overrun_out,
  output logic        timeout_out,
  output logic [2:0]  stage_out,
  output logic [15:0] frame_count_out
);
  typedef enum logic [2:0] {IDLE = 3'd0, LP = 3'd1, CS = 3'd2, LMS = 3'd3, FIR = 3'd4, DONE = 3'd5} state_t;
  state_t      state;
  logic [15:0] cnt;
  logic        pending, in_stage, first, stage_done, accept, tmo, start_frame;
  assign in_stage    = state inside {LP, CS, LMS, FIR};
  assign first       = cnt == 16'd0;
  assign stage_done  = (state == LP)  ? lp_done_in  :
                       (state == CS)  ? cs_done_in  :
                       (state == LMS) ? lms_done_in :
                       (state == FIR) ? fir_done_in : 1'b0;
  // A done in the start cycle is ignored; a done in the timeout cycle still wins.
  assign accept      = in_stage && !first && stage_done;
  assign tmo         = in_stage && !accept && cnt == 16'(TIMEOUT_CYCLES - 1);
  assign start_frame = pending || sample_ready_in;
  assign lp_start_out   = first && state == LP;
  assign cs_start_out   = first && state == CS;
  assign lms_start_out  = first && state == LMS;
  assign fir_start_out  = first && state == FIR;
  assign busy_out       = state != IDLE;
  assign frame_done_out = state == DONE;
  assign stage_out      = state;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      cnt             <= '0;
      pending         <= 1'b0;
      overrun_out     <= 1'b0;
      timeout_out     <= 1'b0;
      frame_count_out <= '0;
    end else begin
      if (tmo) state <= IDLE;
      else
        case (state)
          IDLE:    state <= start_frame ? LP : IDLE;
          LP:      if (accept) state <= CS;
          CS:      if (accept) state <= adapt_en_in ? LMS : FIR;
          LMS:     if (accept) state <= FIR;
          FIR:     if (accept) state <= DONE;
          DONE:    state <= start_frame ? LP : IDLE;
          default: state <= IDLE;
        endcase
      cnt <= (in_stage && !accept && !tmo) ? cnt + 16'd1 : 16'd0;
      // Entering LP from IDLE/DONE consumes pending; a coincident sample becomes the new pending one.
      if (state == IDLE || state == DONE) pending <= pending && sample_ready_in;
      else if (sample_ready_in) pending <= 1'b1;
      overrun_out     <= (in_stage && sample_ready_in && pending) || (overrun_out && !clear_flags_in);
      timeout_out     <= tmo || (timeout_out && !clear_flags_in);
      frame_count_out <= frame_count_out + {15'd0, state == DONE};
    end
  end
endmodule

// File: tb/tb_anc_pipeline_sequencer.sv
// tb_anc_pipeline_sequencer: directed frames with hand-computed expectations.
module tb_anc_pipeline_sequencer;
  logic        clk_in = 1'b0, rst_n_in = 1'b0;
  logic        sample_ready_in = 1'b0, adapt_en_in = 1'b1, clear_flags_in = 1'b0;
  logic        lp_done_in = 1'b0, cs_done_in = 1'b0, lms_done_in = 1'b0, fir_done_in = 1'b0;
  logic        lp_start_out, cs_start_out, lms_start_out, fir_start_out;
  logic        busy_out, frame_done_out, overrun_out, timeout_out;
  logic [2:0]  stage_out;
  logic [15:0] frame_count_out;
  int errors = 0, checks = 0;
  int lms_n = 0, fd_n = 0, lms_base, fd_base;

  anc_pipeline_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .sample_ready_in(sample_ready_in),
    .adapt_en_in(adapt_en_in), .clear_flags_in(clear_flags_in),
    .lp_done_in(lp_done_in), .cs_done_in(cs_done_in), .lms_done_in(lms_done_in), .fir_done_in(fir_done_in),
    .lp_start_out(lp_start_out), .cs_start_out(cs_start_out), .lms_start_out(lms_start_out),
    .fir_start_out(fir_start_out), .busy_out(busy_out), .frame_done_out(frame_done_out),
    .overrun_out(overrun_out), .timeout_out(timeout_out), .stage_out(stage_out),
    .frame_count_out(frame_count_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (lms_start_out) lms_n <= lms_n + 1;
    if (frame_done_out) fd_n <= fd_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_done(input logic [2:0] st, input logic v);
    case (st)
      3'd1: lp_done_in = v;
      3'd2: cs_done_in = v;
      3'd3: lms_done_in = v;
      default: fir_done_in = v;
    endcase
  endtask

  // Called in the start cycle of stage st; raises done d cycles later and pulses a sample in cycle smp.
  task automatic stage_done(input logic [2:0] st, input int d, input int smp);
    check($sformatf("stage%0d", st), stage_out, st);
    check($sformatf("start%0d", st), {fir_start_out, lms_start_out, cs_start_out, lp_start_out}, 4'b0001 << (st - 3'd1));
    for (int i = 0; i < d; i++) begin
      sample_ready_in = (i == smp);
      step();
    end
    sample_ready_in = 1'b0;
    set_done(st, 1'b1);
    step();
    set_done(st, 1'b0);
  endtask

  task automatic sample();
    sample_ready_in = 1'b1;
    step();
    sample_ready_in = 1'b0;
  endtask

  task automatic finish_frame(input logic [15:0] cnt_after);
    check("fd_in_done", frame_done_out, 1);
    check("stage_done", stage_out, 5);
    step();
    check("fd_after", frame_done_out, 0);
    check("count", frame_count_out, cnt_after);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check("rst_stage", stage_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_count", frame_count_out, 0);
    check("rst_flags", {overrun_out, timeout_out, frame_done_out}, 0);
    check("rst_starts", {fir_start_out, lms_start_out, cs_start_out, lp_start_out}, 0);
    rst_n_in = 1'b1;
    step();
    // Single frame, dones 3 cycles after each start, adapt on
    lms_base = lms_n; fd_base = fd_n;
    sample();
    stage_done(1, 3, -1);
    check("lp_pulse_gone", lp_start_out, 0);
    stage_done(2, 3, -1);
    stage_done(3, 3, -1);
    stage_done(4, 3, -1);
    finish_frame(1);
    check("idle_after", stage_out, 0);
    check("busy_after", busy_out, 0);
    check("lms_n_a", lms_n - lms_base, 1);
    check("fd_n_a", fd_n - fd_base, 1);
    // adapt off: CS goes straight to FIR
    lms_base = lms_n;
    sample();
    stage_done(1, 2, -1);
    adapt_en_in = 1'b0;
    stage_done(2, 2, -1);
    adapt_en_in = 1'b1;
    stage_done(4, 2, -1);
    finish_frame(2);
    check("lms_n_b", lms_n - lms_base, 0);
    // Minimum latency: DONE reached 9 edges after the sample cycle
    sample();
    stage_done(1, 1, -1);
    stage_done(2, 1, -1);
    stage_done(3, 1, -1);
    stage_done(4, 1, -1);
    finish_frame(3);
    // Pending in CS, overrun in FIR, pending serviced DONE -> LP
    sample();
    stage_done(1, 2, -1);
    stage_done(2, 3, 0);
    check("ovr_not_yet", overrun_out, 0);
    stage_done(3, 2, -1);
    stage_done(4, 3, 1);
    check("ovr_set", overrun_out, 1);
    check("fd_pend", frame_done_out, 1);
    step();
    check("pend_lp", stage_out, 1);
    check("pend_count", frame_count_out, 4);
    stage_done(1, 1, -1);
    stage_done(2, 1, -1);
    stage_done(3, 1, -1);
    stage_done(4, 1, -1);
    finish_frame(5);
    step();
    check("no_third", stage_out, 0);
    check("ovr_sticky", overrun_out, 1);
    clear_flags_in = 1'b1;
    step();
    clear_flags_in = 1'b0;
    check("ovr_clr", overrun_out, 0);
    // Early dones ignored: lp_done in start cycle, cs_done during LP
    sample();
    check("e_lp_start", lp_start_out, 1);
    lp_done_in = 1'b1; cs_done_in = 1'b1;
    step();
    lp_done_in = 1'b0;
    check("e_ignore_lp", stage_out, 1);
    step();
    cs_done_in = 1'b0;
    check("e_ignore_cs", stage_out, 1);
    lp_done_in = 1'b1;
    step();
    lp_done_in = 1'b0;
    stage_done(2, 1, -1);
    stage_done(3, 1, -1);
    stage_done(4, 1, -1);
    finish_frame(6);
    // Timeout in CS after 8 cycles
    fd_base = fd_n;
    sample();
    stage_done(1, 1, -1);
    repeat (7) step();
    check("t_still_cs", stage_out, 2);
    check("t_not_yet", timeout_out, 0);
    step();
    check("t_idle", stage_out, 0);
    check("t_flag", timeout_out, 1);
    check("t_fd_n", fd_n - fd_base, 0);
    check("t_count", frame_count_out, 6);
    clear_flags_in = 1'b1;
    step();
    clear_flags_in = 1'b0;
    check("t_clr", timeout_out, 0);
    // Done in the last allowed cycle wins over timeout
    sample();
    stage_done(1, 1, -1);
    stage_done(2, 7, -1);
    check("dw_no_tmo", timeout_out, 0);
    stage_done(3, 1, -1);
    stage_done(4, 1, -1);
    finish_frame(7);
    // Timeout abort with pending restarts from IDLE next cycle
    sample();
    stage_done(1, 1, -1);
    sample();
    repeat (7) step();
    check("ta_idle", stage_out, 0);
    check("ta_flag", timeout_out, 1);
    step();
    check("ta_restart", stage_out, 1);
    stage_done(1, 1, -1);
    stage_done(2, 1, -1);
    stage_done(3, 1, -1);
    stage_done(4, 1, -1);
    finish_frame(8);
    // Reset during LMS
    sample();
    stage_done(1, 1, -1);
    stage_done(2, 1, -1);
    check("r_lms", stage_out, 3);
    step();
    rst_n_in = 1'b0;
    #1;
    check("r_stage", stage_out, 0);
    check("r_count", frame_count_out, 0);
    check("r_outs", {busy_out, frame_done_out, overrun_out, timeout_out,
                     fir_start_out, lms_start_out, cs_start_out, lp_start_out}, 0);
    step();
    rst_n_in = 1'b1;
    sample();
    stage_done(1, 1, -1);
    stage_done(2, 1, -1);
    stage_done(3, 1, -1);
    stage_done(4, 1, -1);
    finish_frame(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
